dma_pack_gen: RTL and testbench
===============================

DMA_PACK_GEN -- requirements
Module: dma_pack_gen

Interface
REQ-001 SHALL have parameter IN_W, default 64, meaning DMA beat width in bits (multiple of 8).
REQ-002 SHALL have parameter OUT_W, default 112, meaning buffer word width in bits (multiple of 8, >= 8).
REQ-003 SHALL have parameter ADDR_W, default 7, meaning buffer address width.
REQ-004 SHALL derive localparam BEATS = ceil(OUT_W/IN_W), the number of beats per buffer word.
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports as listed below.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 start  input  1  one-cycle pulse that begins a transfer; sampled only in IDLE.
REQ-009 base_addr  input  ADDR_W  first buffer address of the transfer; latched on accepted start.
REQ-010 in_valid  input  1  DMA beat valid.
REQ-011 in_ready  output  1  packer accepts a beat; a beat transfers when in_valid && in_ready.
REQ-012 in_data  input  IN_W  DMA beat payload.
REQ-013 in_last  input  1  final beat of the transfer; qualified by beat transfer.
REQ-014 buf_we  output  1  buffer write request.
REQ-015 buf_ready  input  1  buffer accepts a write; a write completes when buf_we && buf_ready.
REQ-016 buf_waddr  output  ADDR_W  buffer write address.
REQ-017 buf_wdata  output  OUT_W  packed buffer word.
REQ-018 busy  output  1  high in PACK and DRAIN.
REQ-019 done  output  1  one-cycle pulse when the transfer's final write completes.
REQ-020 words_written  output  ADDR_W+1  count of completed writes in the current or most recent transfer.
REQ-021 err_wrap  output  1  sticky flag, set when buf_waddr wraps from 2^ADDR_W-1 to 0 within a transfer.

Function
REQ-022 SHALL implement the states IDLE, PACK, DRAIN.
  - IDLE -> PACK on start.
  - PACK -> DRAIN on the transfer of the in_last beat.
  - DRAIN -> IDLE when the final write completes.
REQ-023 Accepting start in IDLE SHALL latch base_addr into the write address and clear beat_idx, words_written and err_wrap.
REQ-024 start SHALL be ignored outside IDLE.
REQ-025 in_ready SHALL equal (state==PACK) && (!buf_we || buf_ready).
  - in_ready SHALL be 0 in IDLE and DRAIN.
REQ-026 Beat k of a word (beat_idx k, 0..BEATS-1) SHALL be placed at bits [k*IN_W +: IN_W] of the assembly register.
  - Bits beyond OUT_W SHALL be discarded.
REQ-027 The beat that completes a word (beat_idx==BEATS-1) SHALL cause buf_we=1 on the next cycle, with buf_wdata equal to the assembled word; beat_idx SHALL return to 0.
REQ-028 A partial word SHALL be flushed on in_last when beat_idx < BEATS-1.
  - buf_wdata SHALL carry the received beats in the low bits and zeros in all higher bits.
  - The write SHALL be issued on the next cycle.
REQ-029 While buf_we && !buf_ready, buf_we, buf_waddr and buf_wdata SHALL hold stable, and no beat SHALL be accepted.
REQ-030 Write latency SHALL be exactly 1 cycle from the completing beat to buf_we with buf_ready tied high.
  - Sustained throughput SHALL be 1 beat per cycle, with no bubble between words.
REQ-031 The first word SHALL be written at base_addr.
  - Each completed write SHALL increment the address by 1 modulo 2^ADDR_W.
  - A wrap SHALL set err_wrap, and writing SHALL continue.
REQ-032 words_written SHALL increment on each completed write and saturate at 2^(ADDR_W+1)-1.
REQ-033 done SHALL pulse in the cycle after the final write completes; busy SHALL be 0 in that cycle.
REQ-034 When a completing beat and the previous word's accepted write occur in the same cycle, the new word SHALL load the output register in the same cycle without loss.

Reset
REQ-035 With rst high at a clock edge, the block SHALL enter IDLE, and:
  - buf_we=0, buf_waddr=0, buf_wdata=0;
  - in_ready=0, busy=0, done=0;
  - words_written=0, err_wrap=0;
  - beat_idx=0, assembly register=0.
REQ-036 Reset mid-transfer SHALL discard any partial word without writing it.
  - The first transfer after reset SHALL behave identically to one from power-up.

Verification
REQ-037 Defaults, base_addr=5, beats A then B (B with in_last), buf_ready=1 -> one write at addr 5 with data {B[47:0],A}, then done, words_written=1.
REQ-038 Five beats A..E, E with in_last -> writes at 0,1,2: {B[47:0],A}, {D[47:0],C}, {48'h0,E}; done pulses once.
REQ-039 buf_ready held low for 3 cycles during the first write -> buf_we/addr/data stable, in_ready=0 for those cycles, no beat lost; final data as in REQ-037.
REQ-040 base_addr=127, 4 beats -> writes at 127 then 0, err_wrap=1 after the second write, words_written=2.
REQ-041 rst asserted after 1 beat of a word, then a new start with base_addr=10 and 2 beats -> single write at 10 containing only the new beats.
REQ-042 start pulsed during PACK with base_addr=50 -> ignored; addresses continue from the original base.

Source files
------------

// File: rtl/dma_pack_gen.sv
// dma_pack_gen
// Packs IN_W-bit DMA beats into OUT_W-bit buffer words and writes them to
// consecutive buffer addresses starting at base_addr.
//
// Ports
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   start           : one-cycle pulse that begins a transfer (IDLE only)
//   base_addr       : first write address, latched on an accepted start
//   in_valid/in_ready/in_data/in_last : DMA beat stream (valid/ready)
//   buf_we/buf_ready/buf_waddr/buf_wdata : buffer write port (valid/ready)
//   busy            : transfer in progress (PACK or DRAIN)
//   done            : one-cycle pulse after the final write completes
//   words_written   : saturating count of completed writes this transfer
//   err_wrap        : sticky, write address wrapped inside a transfer
module dma_pack_gen #(
  parameter int IN_W   = 64,
  parameter int OUT_W  = 112,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_last,
  output logic              buf_we,
  input  logic              buf_ready,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic [OUT_W-1:0]  buf_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_written,
  output logic              err_wrap
);

  localparam int BEATS  = (OUT_W + IN_W - 1) / IN_W;
  localparam int ASM_W  = BEATS * IN_W;
  localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PACK  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [BIDX_W-1:0] LAST_IDX  = BIDX_W'(BEATS - 1);
  localparam logic [ADDR_W:0]   WORDS_MAX = {(ADDR_W+1){1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};

  logic [1:0]        state_q, state_d;
  logic [BIDX_W-1:0] beat_idx_q, beat_idx_d;
  logic [ASM_W-1:0]  asm_q, asm_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [OUT_W-1:0]  wdata_q, wdata_d;
  logic              last_q, last_d;     // word in the output register is the transfer's final one
  logic [ADDR_W:0]   words_q, words_d;
  logic              err_q, err_d;
  logic              done_q, done_d;

  logic              beat_fire_s;
  logic              write_fire_s;
  logic              word_done_s;
  logic [ASM_W-1:0]  asm_ins_s;

  assign in_ready     = (state_q == ST_PACK) && (!we_q || buf_ready);
  assign beat_fire_s  = in_valid && in_ready;
  assign write_fire_s = we_q && buf_ready;
  // A word closes on its last beat slot, or early on in_last (partial flush).
  assign word_done_s  = (beat_idx_q == LAST_IDX) || in_last;

  assign buf_we        = we_q;
  assign buf_waddr     = waddr_q;
  assign buf_wdata     = wdata_q;
  assign busy          = (state_q == ST_PACK) || (state_q == ST_DRAIN);
  assign done          = done_q;
  assign words_written = words_q;
  assign err_wrap      = err_q;

  // Assembly register with the incoming beat dropped into its slot.
  always_comb begin
    asm_ins_s = asm_q;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_idx_q == BIDX_W'(k)) begin
        asm_ins_s[k*IN_W +: IN_W] = in_data;
      end else begin
        asm_ins_s[k*IN_W +: IN_W] = asm_q[k*IN_W +: IN_W];
      end
    end
  end

  // Next-state logic for the FSM, packer and write port.
  always_comb begin
    state_d    = state_q;
    beat_idx_d = beat_idx_q;
    asm_d      = asm_q;
    we_d       = we_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    last_d     = last_q;
    words_d    = words_q;
    err_d      = err_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_PACK;
          waddr_d    = base_addr;
          beat_idx_d = '0;
          asm_d      = '0;
          words_d    = '0;
          err_d      = 1'b0;
          last_d     = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PACK: begin
        if (beat_fire_s && in_last) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_PACK;
        end
      end
      ST_DRAIN: begin
        if (write_fire_s && last_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Retire the word currently on the write port.
    if (write_fire_s) begin
      we_d    = 1'b0;
      waddr_d = waddr_q + ADDR_W'(1);
      // Stepping past the top address after the final write is not a wrap
      // inside the transfer, since nothing more is written.
      if ((waddr_q == ADDR_MAX) && !last_q) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
      if (words_q != WORDS_MAX) begin
        words_d = words_q + (ADDR_W+1)'(1);
      end else begin
        words_d = words_q;
      end
      if (last_q) begin
        done_d = 1'b1;
      end else begin
        done_d = 1'b0;
      end
    end else begin
      done_d = 1'b0;
    end

    // Accept a beat; a closing beat may reload the port in the same cycle
    // the previous word retires, since in_ready already guarantees room.
    if (beat_fire_s) begin
      if (word_done_s) begin
        we_d       = 1'b1;
        wdata_d    = asm_ins_s[OUT_W-1:0];
        last_d     = in_last;
        asm_d      = '0;      // unreceived slots of the next word read as zero
        beat_idx_d = '0;
      end else begin
        asm_d      = asm_ins_s;
        beat_idx_d = beat_idx_q + BIDX_W'(1);
      end
    end else begin
      asm_d = asm_d;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      beat_idx_q <= '0;
      asm_q      <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      last_q     <= 1'b0;
      words_q    <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_idx_q <= beat_idx_d;
      asm_q      <= asm_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      last_q     <= last_d;
      words_q    <= words_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_dma_pack_gen.sv
// Directed self-checking bench for dma_pack_gen (default parameters).
module tb_dma_pack_gen;

  localparam int IN_W   = 64;
  localparam int OUT_W  = 112;
  localparam int ADDR_W = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_data;
  logic              in_last;
  logic              buf_we;
  logic              buf_ready;
  logic [ADDR_W-1:0] buf_waddr;
  logic [OUT_W-1:0]  buf_wdata;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   words_written;
  logic              err_wrap;

  dma_pack_gen #(.IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .buf_we(buf_we), .buf_ready(buf_ready), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
    .busy(busy), .done(done), .words_written(words_written), .err_wrap(err_wrap)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Write / done log, sampled at the edge where each handshake completes.
  logic [ADDR_W-1:0] log_a [0:15];
  logic [OUT_W-1:0]  log_d [0:15];
  int nw    = 0;
  int ndone = 0;

  always @(posedge clk) begin
    if (!rst && buf_we && buf_ready) begin
      if (nw < 16) begin
        log_a[nw] = buf_waddr;
        log_d[nw] = buf_wdata;
      end
      nw++;
    end
    if (!rst && done) ndone++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    for (int i = 0; i < 16; i++) begin
      log_a[i] = '0;
      log_d[i] = '0;
    end
    nw    = 0;
    ndone = 0;
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic beat(input logic [IN_W-1:0] d, input logic l, output int cyc);
    logic acc;
    acc = 1'b0;
    cyc = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!acc && cyc < 20) begin
      #1;
      acc = in_ready;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("beat_accept", 128'(acc), 128'(1'b1));
  endtask

  task automatic start_xfer(input logic [ADDR_W-1:0] a);
    base_addr = a;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    logic seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 50) begin
      @(negedge clk);
      cyc++;
      seen = done;
    end
    chk("done_seen", 128'(seen), 128'(1'b1));
  endtask

  logic [IN_W-1:0]  bA, bB, bC, bD, bE, bF, bG;
  logic [OUT_W-1:0] exp_ab, exp_dc, exp_e0, exp_gf;
  int cyc, tot;

  initial begin
    bA = 64'hA0A1_A2A3_A4A5_A6A7;
    bB = 64'hB0B1_B2B3_B4B5_B6B7;
    bC = 64'hC0C1_C2C3_C4C5_C6C7;
    bD = 64'hD0D1_D2D3_D4D5_D6D7;
    bE = 64'hE0E1_E2E3_E4E5_E6E7;
    bF = 64'h1F2F_3F4F_5F6F_7F8F;
    bG = 64'h9192_9394_9596_9798;
    exp_ab = {bB[47:0], bA};
    exp_dc = {bD[47:0], bC};
    exp_e0 = {48'h0, bE};
    exp_gf = {bG[47:0], bF};

    rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0;
    in_data = '0; in_last = 1'b0; buf_ready = 1'b1;
    clear_log();
    @(negedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_buf_we",  128'(buf_we),        128'(1'b0));
    chk("rst_waddr",   128'(buf_waddr),     128'(7'd0));
    chk("rst_wdata",   128'(buf_wdata),     128'(112'd0));
    chk("rst_in_ready",128'(in_ready),      128'(1'b0));
    chk("rst_busy",    128'(busy),          128'(1'b0));
    chk("rst_done",    128'(done),          128'(1'b0));
    chk("rst_words",   128'(words_written), 128'(8'd0));
    chk("rst_err",     128'(err_wrap),      128'(1'b0));
    rst = 1'b0;
    @(negedge clk);

    // Two beats into one word at base 5, cycle-exact
    clear_log();
    start_xfer(7'd5);
    chk("t1_busy_pack", 128'(busy), 128'(1'b1));
    beat(bA, 1'b0, cyc);
    beat(bB, 1'b1, cyc);
    chk("t1_we",       128'(buf_we),    128'(1'b1));
    chk("t1_addr",     128'(buf_waddr), 128'(7'd5));
    chk("t1_data",     128'(buf_wdata), 128'(exp_ab));
    chk("t1_rdy_drain",128'(in_ready),  128'(1'b0));
    chk("t1_busy",     128'(busy),      128'(1'b1));
    chk("t1_done_early",128'(done),     128'(1'b0));
    @(negedge clk);
    chk("t1_done",     128'(done),          128'(1'b1));
    chk("t1_busy_done",128'(busy),          128'(1'b0));
    chk("t1_we_off",   128'(buf_we),        128'(1'b0));
    chk("t1_words",    128'(words_written), 128'(8'd1));
    @(negedge clk);
    chk("t1_done_pulse",128'(done), 128'(1'b0));
    chk("t1_nw",       128'(nw),    128'(32'd1));

    // Five beats back to back, last word partial
    clear_log();
    start_xfer(7'd0);
    tot = 0;
    beat(bA, 1'b0, cyc); tot += cyc;
    beat(bB, 1'b0, cyc); tot += cyc;
    beat(bC, 1'b0, cyc); tot += cyc;
    beat(bD, 1'b0, cyc); tot += cyc;
    beat(bE, 1'b1, cyc); tot += cyc;
    chk("t2_no_bubble", 128'(tot), 128'(32'd5));
    wait_done(cyc);
    chk("t2_done_lat", 128'(cyc), 128'(32'd1));
    repeat (3) @(negedge clk);
    chk("t2_nw",    128'(nw),       128'(32'd3));
    chk("t2_ndone", 128'(ndone),    128'(32'd1));
    chk("t2_a0",    128'(log_a[0]), 128'(7'd0));
    chk("t2_d0",    128'(log_d[0]), 128'(exp_ab));
    chk("t2_a1",    128'(log_a[1]), 128'(7'd1));
    chk("t2_d1",    128'(log_d[1]), 128'(exp_dc));
    chk("t2_a2",    128'(log_a[2]), 128'(7'd2));
    chk("t2_d2",    128'(log_d[2]), 128'(exp_e0));
    chk("t2_words", 128'(words_written), 128'(8'd3));

    // Backpressure on the first write
    clear_log();
    start_xfer(7'd20);
    beat(bA, 1'b0, cyc);
    beat(bB, 1'b0, cyc);
    buf_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = bC;
    in_last   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_rdy_stall", 128'(in_ready),  128'(1'b0));
      chk("t3_we_hold",   128'(buf_we),    128'(1'b1));
      chk("t3_addr_hold", 128'(buf_waddr), 128'(7'd20));
      chk("t3_data_hold", 128'(buf_wdata), 128'(exp_ab));
      @(negedge clk);
    end
    buf_ready = 1'b1;
    beat(bC, 1'b0, cyc);
    beat(bD, 1'b1, cyc);
    wait_done(cyc);
    @(negedge clk);
    chk("t3_nw", 128'(nw),       128'(32'd2));
    chk("t3_a0", 128'(log_a[0]), 128'(7'd20));
    chk("t3_d0", 128'(log_d[0]), 128'(exp_ab));
    chk("t3_a1", 128'(log_a[1]), 128'(7'd21));
    chk("t3_d1", 128'(log_d[1]), 128'(exp_dc));

    // Address wrap from 127
    clear_log();
    start_xfer(7'd127);
    beat(bA, 1'b0, cyc);
    beat(bB, 1'b0, cyc);
    beat(bC, 1'b0, cyc);
    beat(bD, 1'b1, cyc);
    wait_done(cyc);
    @(negedge clk);
    chk("t4_nw",    128'(nw),            128'(32'd2));
    chk("t4_a0",    128'(log_a[0]),      128'(7'd127));
    chk("t4_a1",    128'(log_a[1]),      128'(7'd0));
    chk("t4_err",   128'(err_wrap),      128'(1'b1));
    chk("t4_words", 128'(words_written), 128'(8'd2));

    // Reset mid-word discards the partial word
    clear_log();
    start_xfer(7'd0);
    chk("t5_err_clr", 128'(err_wrap), 128'(1'b0));
    beat(bA, 1'b0, cyc);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy_rst", 128'(busy),   128'(1'b0));
    chk("t5_we_rst",   128'(buf_we), 128'(1'b0));
    clear_log();
    start_xfer(7'd10);
    beat(bF, 1'b0, cyc);
    beat(bG, 1'b1, cyc);
    wait_done(cyc);
    @(negedge clk);
    chk("t5_nw", 128'(nw),       128'(32'd1));
    chk("t5_a0", 128'(log_a[0]), 128'(7'd10));
    chk("t5_d0", 128'(log_d[0]), 128'(exp_gf));

    // start during PACK is ignored
    clear_log();
    start_xfer(7'd30);
    beat(bA, 1'b0, cyc);
    base_addr = 7'd50;
    start     = 1'b1;
    beat(bB, 1'b0, cyc);
    start     = 1'b0;
    beat(bC, 1'b0, cyc);
    beat(bD, 1'b1, cyc);
    wait_done(cyc);
    @(negedge clk);
    chk("t6_nw",    128'(nw),            128'(32'd2));
    chk("t6_a0",    128'(log_a[0]),      128'(7'd30));
    chk("t6_a1",    128'(log_a[1]),      128'(7'd31));
    chk("t6_d1",    128'(log_d[1]),      128'(exp_dc));
    chk("t6_words", 128'(words_written), 128'(8'd2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
